// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - MDU op encoding, default latencies and op classification helpers
package mdu_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_t;

  // Ops that occupy the unit for multiple cycles
  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_mult(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mdu_core.sv
// rtl/mdu_core.sv - combinational 64-bit product, quotient and remainder
module mdu_core (
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        is_signed,
  output logic [63:0] product,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_zero
);

  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [63:0] mag_p;
  logic [31:0] mag_q;
  logic [31:0] mag_r;

  // Signed ops work on magnitudes and restore signs afterwards; the quotient
  // truncates toward zero and the remainder follows the dividend's sign.
  // 0x80000000 / -1 falls out naturally as 0x80000000 with remainder 0.
  assign neg_a = is_signed & op_a[31];
  assign neg_b = is_signed & op_b[31];
  assign mag_a = neg_a ? (~op_a + 32'd1) : op_a;
  assign mag_b = neg_b ? (~op_b + 32'd1) : op_b;

  assign mag_p   = {32'd0, mag_a} * {32'd0, mag_b};
  assign product = (neg_a ^ neg_b) ? (~mag_p + 64'd1) : mag_p;

  // Guard the divider so a zero divisor never produces undefined results
  assign div_zero  = (op_b == 32'd0);
  assign mag_q     = div_zero ? 32'd0 : (mag_a / mag_b);
  assign mag_r     = div_zero ? 32'd0 : (mag_a % mag_b);
  assign quotient  = (neg_a ^ neg_b) ? (~mag_q + 32'd1) : mag_q;
  assign remainder = neg_a ? (~mag_r + 32'd1) : mag_r;

endmodule

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - MDU sequencing FSM, latency counter, HI/LO and stall logic
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        id_is_md,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata,
  output logic        done
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  mdu_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] load_val;
  logic [31:0]      lat_a;
  logic [31:0]      lat_b;
  logic [3:0]       lat_op;

  logic [63:0] product;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_zero;

  mdu_core u_core (
    .op_a      (lat_a),
    .op_b      (lat_b),
    .is_signed (is_signed_op(lat_op)),
    .product   (product),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  assign load_val = is_mult(mdu_op) ? MULT_LOAD : DIV_LOAD;

  // FSM: launch mult/div, count down the fixed latency, commit HI/LO on the last edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      done   <= 1'b0;
      lat_a  <= 32'd0;
      lat_b  <= 32'd0;
      lat_op <= OP_NONE;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (is_muldiv(mdu_op)) begin
              state  <= ST_RUN;
              cnt    <= load_val;
              lat_a  <= a;
              lat_b  <= b;
              lat_op <= mdu_op;
              done   <= (load_val == CNT_W'(1));
            end else if (mdu_op == OP_MTHI) begin
              hi <= a;
            end else if (mdu_op == OP_MTLO) begin
              lo <= a;
            end
          end
        end
        ST_RUN: begin
          // done is registered, so it is raised on the edge entering the final busy cycle
          cnt  <= cnt - CNT_W'(1);
          done <= (cnt == CNT_W'(2));
          if (cnt == CNT_W'(1)) begin
            state <= ST_IDLE;
            if (is_mult(lat_op)) begin
              hi <= product[63:32];
              lo <= product[31:0];
            end else if (!div_zero) begin
              hi <= remainder;
              lo <= quotient;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy  = (state == ST_RUN);
  assign stall = id_is_md & (busy | (start & is_muldiv(mdu_op)));

  // mfhi/mflo read port reflects the current (pre-commit) HI/LO
  always_comb begin
    rdata = 32'd0;
    if (mdu_op == OP_MFHI) rdata = hi;
    else if (mdu_op == OP_MFLO) rdata = lo;
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - randomized self-checking bench for mdu_ctrl against a timestamp model
module tb_mdu_ctrl;
  import mdu_pkg::*;

  localparam int NM = 5;
  localparam int ND = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        id_is_md;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rdata;
  logic        done;

  mdu_ctrl #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mdu_op   (mdu_op),
    .a        (a),
    .b        (b),
    .id_is_md (id_is_md),
    .busy     (busy),
    .stall    (stall),
    .hi       (hi),
    .lo       (lo),
    .rdata    (rdata),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: an operation accepted at cycle T is busy for cycles
  // T+1..T+N and its result becomes architectural after cycle T+N.
  int          cyc;
  int          run_start;
  int          run_end;
  logic [31:0] hi_m;
  logic [31:0] lo_m;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_wr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic model_busy();
    return (cyc > run_start) && (cyc <= run_end);
  endfunction

  task automatic model_launch(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
    longint      sa;
    longint      sb;
    logic [63:0] p;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    pend_wr = 1'b1;
    case (op)
      OP_MULT:  p = 64'(sa * sb);
      OP_MULTU: p = {32'd0, av} * {32'd0, bv};
      OP_DIV: begin
        if (bv == 32'd0) pend_wr = 1'b0;
        else p = {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (bv == 32'd0) pend_wr = 1'b0;
        else p = {av % bv, av / bv};
      end
    endcase
    pend_hi   = p[63:32];
    pend_lo   = p[31:0];
    run_start = cyc;
    run_end   = cyc + (((op == OP_MULT) || (op == OP_MULTU)) ? NM : ND);
  endtask

  task automatic tick(input logic r, input logic s, input logic [3:0] op,
                      input logic [31:0] av, input logic [31:0] bv, input logic im);
    logic        be;
    logic [31:0] rd_e;
    logic        md;
    reset = r; start = s; mdu_op = op; a = av; b = bv; id_is_md = im;
    md = (op >= OP_MULT) && (op <= OP_DIVU);
    @(negedge clk);
    be   = model_busy();
    rd_e = (op == OP_MFHI) ? hi_m : ((op == OP_MFLO) ? lo_m : 32'd0);
    check("busy",  32'(busy),  32'(be));
    check("done",  32'(done),  32'(be && (cyc == run_end)));
    check("stall", 32'(stall), 32'(im && (be || (s && md))));
    check("hi",    hi,    hi_m);
    check("lo",    lo,    lo_m);
    check("rdata", rdata, rd_e);
    @(posedge clk);
    if (r) begin
      hi_m = 32'd0; lo_m = 32'd0; run_start = -1; run_end = -1;
    end else if (be) begin
      if (cyc == run_end && pend_wr) begin
        hi_m = pend_hi; lo_m = pend_lo;
      end
    end else if (s) begin
      if (md) model_launch(op, av, bv);
      else if (op == OP_MTHI) hi_m = av;
      else if (op == OP_MTLO) lo_m = av;
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n, input logic im);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, OP_NONE, 32'd0, 32'd0, im);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    cyc = 0; run_start = -1; run_end = -1;
    hi_m = 32'd0; lo_m = 32'd0; pend_hi = 32'd0; pend_lo = 32'd0; pend_wr = 1'b0;
    reset = 1'b1; start = 1'b0; mdu_op = OP_NONE; a = 32'd0; b = 32'd0; id_is_md = 1'b0;
    @(posedge clk); #1;

    // Reset state, including stall and rdata during reset
    tick(1'b1, 1'b1, OP_MULT, 32'd1, 32'd1, 1'b1);
    tick(1'b1, 1'b0, OP_MFHI, 32'd0, 32'd0, 1'b0);

    // MULT -2 * 3
    tick(1'b0, 1'b1, OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
    idle(NM, 1'b0);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);

    // DIVU 7/2 then DIV -7/2 back-to-back
    tick(1'b0, 1'b1, OP_DIVU, 32'd7, 32'd2, 1'b0);
    idle(ND - 1, 1'b0);
    tick(1'b0, 1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
    check("divu_lo", lo, 32'd3);
    check("divu_hi", hi, 32'd1);
    tick(1'b0, 1'b1, OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    idle(ND, 1'b0);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    // Signed overflow case
    tick(1'b0, 1'b1, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle(ND, 1'b0);
    check("ovf_lo", lo, 32'h8000_0000);
    check("ovf_hi", hi, 32'd0);

    // Divide by zero leaves preloaded HI/LO
    tick(1'b0, 1'b1, OP_MTHI, 32'h11, 32'd0, 1'b0);
    tick(1'b0, 1'b1, OP_MTLO, 32'h22, 32'd0, 1'b0);
    tick(1'b0, 1'b1, OP_DIV, 32'd99, 32'd0, 1'b0);
    idle(ND, 1'b0);
    check("dz_hi", hi, 32'h11);
    check("dz_lo", lo, 32'h22);

    // DIV under id_is_md with an ignored mid-run start
    tick(1'b0, 1'b1, OP_DIV, 32'd100, 32'd7, 1'b1);
    idle(3, 1'b1);
    tick(1'b0, 1'b1, OP_MULT, 32'd5, 32'd5, 1'b1);
    tick(1'b0, 1'b1, OP_MTHI, 32'hDEAD, 32'd0, 1'b1);
    idle(ND - 5, 1'b1);
    idle(2, 1'b1);
    check("ign_lo", lo, 32'd14);
    check("ign_hi", hi, 32'd2);

    // Reset at busy cycle 3 of MULT, then MTLO/MFLO
    tick(1'b0, 1'b1, OP_MULT, 32'd9, 32'd9, 1'b0);
    idle(2, 1'b0);
    tick(1'b1, 1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
    idle(NM + 1, 1'b0);
    check("rst_lo", lo, 32'd0);
    tick(1'b0, 1'b1, OP_MTLO, 32'd5, 32'd0, 1'b0);
    tick(1'b0, 1'b0, OP_MFLO, 32'd0, 32'd0, 1'b0);
    check("mflo", rdata, 32'd5);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      tick(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) != 0),
           4'($urandom_range(0, 15)), rand_operand(), rand_operand(), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Sequencing controller for the multiply/divide resource in the EX stage of the 5-stage MIPS pipeline. It accepts one MDU operation per start pulse, latches the operands, models the fixed multi-cycle latency with a down-counter, commits results to the architectural HI/LO registers, and generates `busy` and the ID-stage stall request so that dependent MDU instructions wait. It also services the single-cycle `mthi`/`mtlo` writes and `mfhi`/`mflo` reads.

## Interface

Parameters:
- `MULT_CYCLES`, default 5: busy cycles for `mult`/`multu`; must be ≥1.
- `DIV_CYCLES`, default 10: busy cycles for `div`/`divu`; must be ≥1.

Ports:
- `clk`  in  1: the only clock; all state is updated on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: an EX-stage MDU instruction is valid this cycle.
- `mdu_op`  in  4: operation code, from the `mdu_pkg` encoding.
- `a`  in  32: rs operand, already forwarded.
- `b`  in  32: rt operand, already forwarded.
- `id_is_md`  in  1: the instruction in ID is an MDU instruction (any of the 8 ops).
- `busy`  out  1: a mult/div operation is in flight.
- `stall`  out  1: freeze IF/ID and bubble ID/EX.
- `hi`  out  32: architectural HI register.
- `lo`  out  32: architectural LO register.
- `rdata`  out  32: `mfhi`/`mflo` result.
- `done`  out  1: one-cycle pulse in the final busy cycle.

## Operation

- Op encoding: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8. Codes 9–15 are treated as NONE.
- FSM states:
  - IDLE → RUN on `start` with MULT/MULTU/DIV/DIVU. The counter loads `MULT_CYCLES` or `DIV_CYCLES`; `a`, `b` and the op are latched.
  - RUN: the counter decrements every cycle. When the counter is 1, the next edge commits HI/LO and returns the FSM to IDLE.
- MULT/MULTU: {HI,LO} = 64-bit signed or unsigned product.
- DIV/DIVU: LO = quotient, HI = remainder.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (signed): LO=0x80000000, HI=0.
  - Divisor 0: full latency runs, `done` still pulses, and HI/LO are left unchanged.
- MTHI/MTLO in IDLE: HI or LO ← `a` at the edge; no busy cycles.
- MFHI/MFLO: `rdata` is combinational, HI or LO for the current `mdu_op`, otherwise 0. Reads return the pre-commit values; the pipeline never issues them while busy.
- `start` while in RUN, with any op: ignored, with no effect on the counter, latched operands or HI/LO.
- `busy` = (state == RUN).
- `stall` = `id_is_md` & (`busy` | (`start` & `mdu_op` ∈ {MULT, MULTU, DIV, DIVU})).
- `reset` wins over everything, including an in-progress operation: state IDLE, counter 0, HI=LO=0, and no commit of the partial result.

## Timing

- Reset values: `busy`=0, `stall`=0 unless `id_is_md` is set and `start` carries a mult/div op, `done`=0, `hi`=0, `lo`=0, `rdata`=0 unless `mdu_op` is MFHI/MFLO (then the reset HI/LO, 0).
- Mult/div with `start` in cycle T:
  - `busy`=1 in cycles T+1 … T+N, where N is the parameter for the op.
  - `done`=1 in cycle T+N only.
  - New HI/LO visible from T+N+1.
  - `busy`=0 at T+N+1.
- Back-to-back: a new `start` in cycle T+N+1 is accepted.
- MTHI/MTLO with `start` in cycle T: the new value is visible at T+1.
- `stall` is combinational in the same cycle; it depends on `start` in cycle T, so it already covers cycle T.

## Structure

- `mdu_pkg`: op encoding constants, default latencies, and the helper `is_muldiv(op)`.
- Sub-module `mdu_core`: purely combinational 64-bit product, quotient and remainder from the latched operands plus signed/unsigned select, with a divide-by-zero flag output.
- `mdu_ctrl` holds the FSM, the counter, the operand latches, HI/LO, and the stall/busy/done logic.

## Test plan

- MULT: `a`=0xFFFFFFFE (−2), `b`=3, `start` at T → `busy` high T+1..T+5, `done` at T+5, HI=0xFFFFFFFF and LO=0xFFFFFFFA at T+6.
- DIVU: `a`=7, `b`=2 → after 10 busy cycles, LO=3, HI=1. DIV: `a`=−7, `b`=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV by 0 with HI=0x11, LO=0x22 preloaded via MTHI/MTLO → 10 busy cycles, `done` pulses, HI/LO remain 0x11/0x22.
- `id_is_md`=1 during a DIV: `stall`=1 from the start cycle through the last busy cycle and 0 after. A `start` injected mid-run is ignored; HI/LO hold the first result.
- `reset` asserted at busy cycle 3 of MULT → next cycle `busy`=0, HI=LO=0, no `done`. A following MTLO `a`=5 gives LO=5 one cycle later, and MFLO gives `rdata`=5.
